signal_table_sequencer: RTL and testbench

//  Controller for the single-port synchronous signal table. Steps the read address 0..data_range-1
//  at a programmable sample rate and delivers each sample to the PWM duty register.

---
 rtl/signal_table_sequencer_pkg.sv | 14 +
 rtl/signal_table_sequencer_rate_divider.sv | 44 ++++
 rtl/signal_table_sequencer.sv | 115 +++++++++++
 tb/tb_signal_table_sequencer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/signal_table_sequencer_pkg.sv
// Shared definitions for the signal table sequencer: FSM state encoding and
// the minimum divider setting that keeps the sample period at 4 cycles or more.
package signal_table_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    CAP  = 2'd2,
    WR   = 2'd3
  } seq_state_t;

  localparam int RATE_MIN = 3;

endpackage

// File: rtl/signal_table_sequencer_rate_divider.sv
// Sample-rate divider: counts 0..Rate_eff while enabled and flags the last count.
// Rate values below RATE_MIN are raised to RATE_MIN.
module signal_table_sequencer_rate_divider
  import signal_table_sequencer_pkg::*;
#(
  parameter int rate_width = 16
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Enable,
  input  logic [rate_width-1:0] Rate,
  output logic                  tick
);

  logic [rate_width-1:0] rate_eff;
  logic [rate_width-1:0] cnt_reg;
  logic [rate_width-1:0] cnt_next;

  always_comb begin
    rate_eff = (Rate < rate_width'(RATE_MIN)) ? rate_width'(RATE_MIN) : Rate;
  end

  assign tick = Enable && (cnt_reg == rate_eff);

  // A count already above a newly lowered Rate runs on through the full
  // counter range before it can match again.
  always_comb begin
    cnt_next = cnt_reg + 1'b1;
    if (!Enable) begin
      cnt_next = '0;
    end else if (cnt_reg == rate_eff) begin
      cnt_next = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/signal_table_sequencer.sv
// Plays the signal table back to the PWM duty register at a programmable rate,
// sharing the table's single port with host reloads (reads take priority).
module signal_table_sequencer
  import signal_table_sequencer_pkg::*;
#(
  parameter int data_width = 8,
  parameter int addr_width = 7,
  parameter int data_range = 100,
  parameter int rate_width = 16
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Enable,
  input  logic [rate_width-1:0] Rate,
  input  logic                  WrReq,
  input  logic [addr_width-1:0] WrAddr,
  input  logic [data_width-1:0] WrData,
  output logic                  WrAck,
  output logic                  mem_WR,
  output logic [addr_width-1:0] mem_address,
  output logic [data_width-1:0] mem_dataIn,
  input  logic [data_width-1:0] mem_dataOut,
  output logic [data_width-1:0] Sample,
  output logic                  SampleValid,
  output logic                  Wrap
);

  localparam logic [addr_width-1:0] LAST_ADDR = addr_width'(data_range - 1);

  seq_state_t            state_reg, state_next;
  logic                  tick;
  logic                  tick_pend_reg, tick_pend_next;
  logic [addr_width-1:0] rd_ptr_reg, rd_ptr_next;
  logic [data_width-1:0] sample_reg, sample_next;
  logic                  sample_valid_reg, sample_valid_next;
  logic                  wrap_reg, wrap_next;

  signal_table_sequencer_rate_divider #(
    .rate_width(rate_width)
  ) u_rate_divider (
    .Clk   (Clk),
    .Rst   (Rst),
    .Enable(Enable),
    .Rate  (Rate),
    .tick  (tick)
  );

  always_comb begin
    state_next        = state_reg;
    rd_ptr_next       = rd_ptr_reg;
    sample_next       = sample_reg;
    sample_valid_next = 1'b0;
    wrap_next         = 1'b0;
    mem_WR            = 1'b0;
    mem_address       = rd_ptr_reg;
    mem_dataIn        = '0;
    WrAck             = 1'b0;

    case (state_reg)
      IDLE: begin
        if (tick || tick_pend_reg) begin
          state_next = RD;
        end else if (WrReq) begin
          state_next = WR;
        end
      end
      RD: begin
        state_next = CAP;
      end
      CAP: begin
        sample_next       = mem_dataOut;
        sample_valid_next = 1'b1;
        wrap_next         = (rd_ptr_reg == LAST_ADDR);
        rd_ptr_next       = (rd_ptr_reg == LAST_ADDR) ? '0 : rd_ptr_reg + 1'b1;
        state_next        = IDLE;
      end
      WR: begin
        mem_WR      = 1'b1;
        mem_address = WrAddr;
        mem_dataIn  = WrData;
        WrAck       = 1'b1;
        state_next  = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // A tick landing during a write is remembered until the read starts.
    tick_pend_next = (state_next == RD) ? 1'b0 : (tick_pend_reg | tick);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg        <= IDLE;
      tick_pend_reg    <= 1'b0;
      rd_ptr_reg       <= '0;
      sample_reg       <= '0;
      sample_valid_reg <= 1'b0;
      wrap_reg         <= 1'b0;
    end else begin
      state_reg        <= state_next;
      tick_pend_reg    <= tick_pend_next;
      rd_ptr_reg       <= rd_ptr_next;
      sample_reg       <= sample_next;
      sample_valid_reg <= sample_valid_next;
      wrap_reg         <= wrap_next;
    end
  end

  assign Sample      = sample_reg;
  assign SampleValid = sample_valid_reg;
  assign Wrap        = wrap_reg;

endmodule

// File: tb/tb_signal_table_sequencer.sv
// Bench for signal_table_sequencer: table memory model, tick/pointer reference
// model feeding a scoreboard, and scenario tasks for timing and arbitration.
module tb_signal_table_sequencer;

  localparam int DW = 8;
  localparam int AW = 7;
  localparam int DR = 100;
  localparam int RW = 16;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          Enable;
  logic [RW-1:0] Rate;
  logic          WrReq;
  logic [AW-1:0] WrAddr;
  logic [DW-1:0] WrData;
  logic          WrAck;
  logic          mem_WR;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_dataIn;
  logic [DW-1:0] mem_dataOut;
  logic [DW-1:0] Sample;
  logic          SampleValid;
  logic          Wrap;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 Clk = ~Clk;

  signal_table_sequencer #(
    .data_width(DW), .addr_width(AW), .data_range(DR), .rate_width(RW)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Enable(Enable), .Rate(Rate),
    .WrReq(WrReq), .WrAddr(WrAddr), .WrData(WrData), .WrAck(WrAck),
    .mem_WR(mem_WR), .mem_address(mem_address), .mem_dataIn(mem_dataIn),
    .mem_dataOut(mem_dataOut), .Sample(Sample), .SampleValid(SampleValid), .Wrap(Wrap)
  );

  // Single-port synchronous table with a preload path for start-up
  logic [DW-1:0] mem [0:127];
  logic          preload;

  always @(posedge Clk) begin
    if (preload) begin
      for (int i = 0; i < 128; i++) mem[i] <= DW'(i);
    end else if (mem_WR) begin
      mem[mem_address] <= mem_dataIn;
    end
    mem_dataOut <= mem[mem_address];
  end

  always @(posedge Clk) cyc <= cyc + 1;

  // Reference model: divider + pointer, pushes one expected sample per tick
  typedef struct {
    logic [DW-1:0] val;
    logic          wrap;
    int            tick_cyc;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  logic [DW-1:0] ref_table [0:127];
  logic [RW-1:0] m_cnt;
  int            m_ptr;

  function automatic logic [RW-1:0] rate_eff_f(input logic [RW-1:0] r);
    return (r < RW'(3)) ? RW'(3) : r;
  endfunction

  always @(posedge Clk) begin
    if (Rst) begin
      m_cnt <= '0;
      m_ptr <= 0;
      sb.delete();
    end else if (!Enable) begin
      m_cnt <= '0;
    end else if (m_cnt == rate_eff_f(Rate)) begin
      m_cnt <= '0;
      sb.push_back('{val: ref_table[m_ptr], wrap: (m_ptr == DR - 1), tick_cyc: cyc});
      m_ptr <= (m_ptr == DR - 1) ? 0 : m_ptr + 1;
    end else begin
      m_cnt <= m_cnt + 1'b1;
    end
  end

  // Scoreboard check on every SampleValid: value, wrap flag and tick latency
  always @(negedge Clk) begin
    if (SampleValid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: cycle %0d got sample=%0h with no pending tick", cyc, Sample);
      end else begin
        mon_e = sb.pop_front();
        if (Sample !== mon_e.val || Wrap !== mon_e.wrap ||
            (cyc - mon_e.tick_cyc) < 3 || (cyc - mon_e.tick_cyc) > 4) begin
          errors++;
          $display("FAIL sb_sample: cycle %0d got sample=%0h wrap=%0b latency=%0d, expected sample=%0h wrap=%0b latency 3..4",
                   cyc, Sample, Wrap, cyc - mon_e.tick_cyc, mon_e.val, mon_e.wrap);
        end
      end
    end
  end

  task automatic test_reset;
    Rst = 1'b1;
    preload = 1'b1;
    repeat (2) @(negedge Clk);
    checks++; if (Sample !== 8'h00) begin errors++; $display("FAIL reset_sample: got %0h expected 0", Sample); end
    checks++; if (SampleValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", SampleValid); end
    checks++; if (Wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %0b expected 0", Wrap); end
    checks++; if (WrAck !== 1'b0) begin errors++; $display("FAIL reset_wrack: got %0b expected 0", WrAck); end
    checks++; if (mem_WR !== 1'b0) begin errors++; $display("FAIL reset_memwr: got %0b expected 0", mem_WR); end
    checks++; if (mem_address !== 7'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", mem_address); end
    checks++; if (mem_dataIn !== 8'h00) begin errors++; $display("FAIL reset_datain: got %0h expected 0", mem_dataIn); end
    Rst = 1'b0;
    preload = 1'b0;
  endtask

  task automatic test_playback;
    int k0, last, n, wraps;
    Rate = 16'd9;
    Enable = 1'b1;
    k0 = cyc;
    n = 0; wraps = 0; last = 0;
    for (int c = 0; c < 1100 && n < 101; c++) begin
      @(negedge Clk);
      if (SampleValid === 1'b1) begin
        checks++;
        if (n == 0) begin
          if (cyc !== k0 + 12) begin errors++; $display("FAIL play_first_latency: got cycle %0d expected %0d", cyc, k0 + 12); end
        end else if (cyc - last !== 10) begin
          errors++; $display("FAIL play_period: got %0d cycles expected 10", cyc - last);
        end
        if (Wrap === 1'b1) wraps++;
        last = cyc;
        n++;
      end
    end
    checks++; if (n !== 101) begin errors++; $display("FAIL play_count: got %0d samples expected 101", n); end
    checks++; if (wraps !== 1) begin errors++; $display("FAIL play_wraps: got %0d expected 1", wraps); end
  endtask

  task automatic test_clamp;
    int last, n;
    Rate = 16'd0;
    last = cyc;
    n = 0;
    for (int c = 0; c < 1000 && n < 200; c++) begin
      @(negedge Clk);
      if (SampleValid === 1'b1) begin
        checks++;
        if (cyc - last !== 4) begin errors++; $display("FAIL clamp_period: got %0d cycles expected 4", cyc - last); end
        last = cyc;
        n++;
      end
    end
    checks++; if (n !== 200) begin errors++; $display("FAIL clamp_count: got %0d samples expected 200", n); end
  endtask

  task automatic test_collision;
    int s, ack_cyc, sv_cyc;
    bit found;
    Rate = 16'd9;
    s = cyc;
    ack_cyc = -1; sv_cyc = -1;
    repeat (7) @(negedge Clk);
    WrReq = 1'b1; WrAddr = 7'd5; WrData = 8'hAA;
    for (int c = 0; c < 6; c++) begin
      @(negedge Clk);
      if (WrAck === 1'b1 && ack_cyc < 0) begin
        ack_cyc = cyc;
        WrReq = 1'b0;
        ref_table[5] = 8'hAA;
      end
      if (SampleValid === 1'b1 && sv_cyc < 0) sv_cyc = cyc;
    end
    WrReq = 1'b0;
    checks++; if (sv_cyc !== s + 10) begin errors++; $display("FAIL coll_read_first: sample at %0d expected %0d", sv_cyc, s + 10); end
    checks++; if (ack_cyc !== s + 11) begin errors++; $display("FAIL coll_wrack: ack at %0d expected %0d", ack_cyc, s + 11); end
    found = 1'b0;
    for (int c = 0; c < 1200 && !found; c++) begin
      @(negedge Clk);
      if (SampleValid === 1'b1 && Sample === 8'hAA) found = 1'b1;
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL coll_readback: sample 0xAA seen=%0b expected 1", found); end
  endtask

  task automatic test_write_at_tick;
    int s, ack_cyc, sv_cyc;
    s = cyc;
    ack_cyc = -1; sv_cyc = -1;
    repeat (6) @(negedge Clk);
    WrReq = 1'b1; WrAddr = 7'd120; WrData = 8'h33;
    for (int c = 0; c < 7; c++) begin
      @(negedge Clk);
      if (WrAck === 1'b1 && ack_cyc < 0) begin
        ack_cyc = cyc;
        WrReq = 1'b0;
      end
      if (SampleValid === 1'b1 && sv_cyc < 0) sv_cyc = cyc;
    end
    WrReq = 1'b0;
    checks++; if (ack_cyc !== s + 7) begin errors++; $display("FAIL wtick_wrack: ack at %0d expected %0d", ack_cyc, s + 7); end
    checks++; if (sv_cyc !== s + 11) begin errors++; $display("FAIL wtick_delay: sample at %0d expected %0d", sv_cyc, s + 11); end
    checks++; if (mem[120] !== 8'h33) begin errors++; $display("FAIL wtick_data: mem[120]=%0h expected 33", mem[120]); end
  endtask

  task automatic test_pause;
    int k0, n, sv_cyc;
    logic [DW-1:0] got;
    bit found;
    found = 1'b0;
    for (int c = 0; c < 1200 && !found; c++) begin
      @(negedge Clk);
      if (SampleValid === 1'b1 && Sample === 8'd41) found = 1'b1;
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL pause_find41: seen=%0b expected 1", found); end
    Enable = 1'b0;
    n = 0;
    repeat (100) begin
      @(negedge Clk);
      if (SampleValid === 1'b1) n++;
    end
    checks++; if (n !== 0) begin errors++; $display("FAIL pause_quiet: got %0d samples expected 0", n); end
    Enable = 1'b1;
    k0 = cyc;
    sv_cyc = -1; got = '0;
    for (int c = 0; c < 30 && sv_cyc < 0; c++) begin
      @(negedge Clk);
      if (SampleValid === 1'b1) begin sv_cyc = cyc; got = Sample; end
    end
    checks++; if (sv_cyc !== k0 + 12) begin errors++; $display("FAIL pause_resume_time: sample at %0d expected %0d", sv_cyc, k0 + 12); end
    checks++; if (got !== 8'd42) begin errors++; $display("FAIL pause_resume_value: got %0d expected 42", got); end
  endtask

  task automatic test_reset_mid;
    int s, n;
    int sv_cyc [2];
    logic [DW-1:0] got [2];
    s = -1;
    for (int c = 0; c < 30 && s < 0; c++) begin
      @(negedge Clk);
      if (SampleValid === 1'b1) s = cyc;
    end
    WrReq = 1'b1; WrAddr = 7'd121; WrData = 8'h44;
    @(negedge Clk);
    checks++; if (WrAck !== 1'b1) begin errors++; $display("FAIL rst_wr_ack: got %0b expected 1", WrAck); end
    WrReq = 1'b0;
    Rst = 1'b1;
    @(negedge Clk);
    checks++; if (Sample !== 8'h00) begin errors++; $display("FAIL rst_mid_sample: got %0h expected 0", Sample); end
    checks++; if (SampleValid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %0b expected 0", SampleValid); end
    checks++; if (mem_WR !== 1'b0 || WrAck !== 1'b0) begin errors++; $display("FAIL rst_mid_wr: mem_WR=%0b WrAck=%0b expected 0 0", mem_WR, WrAck); end
    checks++; if (mem_address !== 7'd0) begin errors++; $display("FAIL rst_mid_ptr: got %0d expected 0", mem_address); end
    @(negedge Clk);
    Rst = 1'b0;
    checks++; if (mem[121] !== 8'h44) begin errors++; $display("FAIL rst_wr_done: mem[121]=%0h expected 44", mem[121]); end
    s = cyc;
    n = 0;
    sv_cyc[0] = -1; sv_cyc[1] = -1; got[0] = '1; got[1] = '1;
    for (int c = 0; c < 40 && n < 2; c++) begin
      @(negedge Clk);
      if (SampleValid === 1'b1) begin sv_cyc[n] = cyc; got[n] = Sample; n++; end
    end
    checks++; if (sv_cyc[0] !== s + 12) begin errors++; $display("FAIL rst_restart_time: sample at %0d expected %0d", sv_cyc[0], s + 12); end
    checks++; if (got[0] !== 8'd0 || got[1] !== 8'd1) begin errors++; $display("FAIL rst_restart_values: got %0d,%0d expected 0,1", got[0], got[1]); end
  endtask

  task automatic test_drain;
    Enable = 1'b0;
    repeat (12) @(negedge Clk);
    checks++; if (sb.size() !== 0) begin errors++; $display("FAIL drain_pending: %0d expected samples never delivered", sb.size()); end
  endtask

  initial begin
    Rst = 1'b1; preload = 1'b1; Enable = 1'b0; Rate = 16'd9;
    WrReq = 1'b0; WrAddr = '0; WrData = '0;
    for (int i = 0; i < 128; i++) ref_table[i] = DW'(i);
    test_reset();
    test_playback();
    test_clamp();
    test_collision();
    test_write_at_tick();
    test_pause();
    test_reset_mid();
    test_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
